// File: rtl/axis_i2c_master_if.sv
// ---------------------------------------------------------------------------
// axis_if : minimal AXI-Stream bundle (tdata/tvalid/tready).
//   WIDTH         tdata width in bits
//   modport master : drives tdata/tvalid, receives tready
//   modport slave  : receives tdata/tvalid, drives tready
// ---------------------------------------------------------------------------
interface axis_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_master.sv
// ---------------------------------------------------------------------------
// axis_i2c_master : single-byte I2C master fed by a 16-bit AXI-Stream command.
// Each command runs START, {addr,rw}, ACK, one data byte, ACK, STOP.
//   clk_i    system clock
//   arstn_i  asynchronous active-low reset
//   s_axis   command: tdata[15:9] addr, tdata[8] rw (1=read), tdata[7:0] data
//   m_axis   read data byte returned after a read transaction
//   scl_o    SCL (1 = released, 0 = drive low)
//   sda_o    SDA drive (1 = released, 0 = drive low)
//   sda_i    SDA pad sample, already synchronised
//   busy_o   high from command acceptance until STOP completes
//   nack_o   one-cycle pulse on a NACK from the slave
// ---------------------------------------------------------------------------
module axis_i2c_master #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned I2C_FREQ   = 100_000
) (
    input  logic  clk_i,
    input  logic  arstn_i,
    axis_if.slave  s_axis,
    axis_if.master m_axis,
    output logic  scl_o,
    output logic  sda_o,
    input  logic  sda_i,
    output logic  busy_o,
    output logic  nack_o
);

    localparam int unsigned QDIV     = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned CW       = (QDIV > 2) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QDIV - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            qtr_q, qtr_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic [7:0]            rx_q, rx_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  nack_q, nack_d;
    logic                  scl_q, scl_d;
    logic                  sda_q, sda_d;
    logic                  mvalid_q, mvalid_d;
    logic [7:0]            mdata_q, mdata_d;
    logic                  rdy_q;
    logic                  tick;
    logic                  s_ready;

    // Line levels for a given state/quarter. Data bits hold SDA for the whole
    // bit so SDA only moves at the q0 boundary while SCL is low.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] q,
                                              input logic [2:0] b,
                                              input logic [DATA_WIDTH-1:0] c);
        logic       bscl;
        logic [7:0] ab;
        logic [7:0] wb;
        bscl = q[0] ^ q[1];
        ab   = c[15:8];
        wb   = c[7:0];
        case (st)
            ST_IDLE:  line_drive = 2'b11;
            ST_START: line_drive = (q == 2'd0) ? 2'b11 : ((q == 2'd3) ? 2'b00 : 2'b10);
            ST_ADDR:  line_drive = {bscl, ab[b]};
            ST_WRITE: line_drive = {bscl, wb[b]};
            ST_STOP:  line_drive = (q == 2'd0) ? 2'b00 : ((q == 2'd3) ? 2'b11 : 2'b10);
            default:  line_drive = {bscl, 1'b1};
        endcase
    endfunction

    // rdy_q keeps tready low while reset is asserted and for the first cycle after.
    assign s_ready       = (state_q == ST_IDLE) & ~mvalid_q & rdy_q;
    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = mvalid_q;
    assign m_axis.tdata  = mdata_q;
    assign scl_o         = scl_q;
    assign sda_o         = sda_q;
    assign busy_o        = busy_q;
    assign nack_o        = nack_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        cmd_d    = cmd_q;
        rx_d     = rx_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        nack_d   = 1'b0;
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        tick     = 1'b0;

        if (mvalid_q && m_axis.tready) begin
            mvalid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (s_axis.tvalid && s_ready) begin
                cmd_d   = s_axis.tdata;
                busy_d  = 1'b1;
                qtr_d   = '0;
                state_d = ST_START;
            end
        end else begin
            tick  = (cnt_q == CNT_MAX);
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        if (tick) begin
            // q1->q2 boundary: SCL is high, sample the slave
            if (qtr_q == 2'd1) begin
                case (state_q)
                    ST_ADDR_ACK, ST_WRITE_ACK: begin
                        ack_d  = sda_i;
                        nack_d = sda_i;
                    end
                    ST_READ: rx_d = {rx_q[6:0], sda_i};
                    default: ;
                endcase
            end
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
                case (state_q)
                    ST_START: begin
                        bit_d   = 3'd7;
                        state_d = ST_ADDR;
                    end
                    ST_ADDR: begin
                        if (bit_q == 3'd0) state_d = ST_ADDR_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    ST_ADDR_ACK: begin
                        bit_d = 3'd7;
                        if (ack_q)         state_d = ST_STOP;
                        else if (cmd_q[8]) state_d = ST_READ;
                        else               state_d = ST_WRITE;
                    end
                    ST_WRITE: begin
                        if (bit_q == 3'd0) state_d = ST_WRITE_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    ST_WRITE_ACK: state_d = ST_STOP;
                    ST_READ: begin
                        if (bit_q == 3'd0) state_d = ST_READ_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    ST_READ_ACK: begin
                        mdata_d  = rx_q;
                        mvalid_d = 1'b1;
                        state_d  = ST_STOP;
                    end
                    ST_STOP: begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        {scl_d, sda_d} = line_drive(state_d, qtr_d, bit_d, cmd_d);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            cmd_q    <= '0;
            rx_q     <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            nack_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            cmd_q    <= cmd_d;
            rx_q     <= rx_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            nack_q   <= nack_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            rdy_q    <= 1'b1;
        end
    end

endmodule
